dct_transpose_buf: RTL

//  Transpose memory between the row (first-pass) 1-D DCT and the column
//  (second-pass) 1-D DCT of the 8x8 JPEG 2-D DCT. It accepts eight 8x9-bit
//  row-DCT result vectors and emits them as eight column vectors. It is

---
 rtl/dct_transpose_buf.sv | 108 ++++++++++
 1 files changed

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf
// Ping-pong transpose memory sitting between the row and column 1-D DCT
// passes of an 8x8 2-D DCT. Rows are written into one bank while columns of
// the previously completed block are read out of the other bank.
module dct_transpose_buf #(
  parameter int W = 9,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_col
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Two banks of N rows by N coefficients.
  logic [W-1:0] mem [2][N][N];

  logic [1:0]    full;
  logic          wr_sel;
  logic          rd_sel;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;

  logic wr_fire;
  logic rd_fire;

  // Handshakes depend only on registered full flags, so in_ready never
  // combinationally follows out_ready.
  assign in_ready  = !full[wr_sel];
  assign out_valid = full[rd_sel];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Column rd_cnt of the read bank: lane r carries row r of that column.
  for (genvar r = 0; r < N; r++) begin : g_lane
    assign out_col[N*W-1-r*W -: W] = mem[rd_sel][r][rd_cnt];
  end

  // Row storage: an accepted row lands in row wr_cnt of the write bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            mem[b][r][c] <= '0;
          end
        end
      end
    end else if (wr_fire) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_sel][wr_cnt][c] <= in_row[N*W-1-c*W -: W];
      end
    end
  end

  // Write pointer: advance per row, hop to the other bank after the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel <= 1'b0;
      wr_cnt <= '0;
    end else if (wr_fire) begin
      if (wr_cnt == LAST) begin
        wr_sel <= !wr_sel;
        wr_cnt <= '0;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Read pointer: advance per column, hop to the other bank after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel <= 1'b0;
      rd_cnt <= '0;
    end else if (rd_fire) begin
      if (rd_cnt == LAST) begin
        rd_sel <= !rd_sel;
        rd_cnt <= '0;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Full flags: completion and release always touch different banks, so both
  // updates in one cycle cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      if (wr_fire && (wr_cnt == LAST)) begin
        full[wr_sel] <= 1'b1;
      end
      if (rd_fire && (rd_cnt == LAST)) begin
        full[rd_sel] <= 1'b0;
      end
    end
  end

endmodule
